// File: rtl/alu_writeback_pkg.sv
// Shared ALU definitions: opcodes, condition codes, flag bit positions and the
// result-FIFO entry layout.
package alu_writeback_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [3:0] {
    COND_AL = 4'd0,  COND_EQ = 4'd1,  COND_NE = 4'd2,  COND_CS = 4'd3,
    COND_CC = 4'd4,  COND_MI = 4'd5,  COND_PL = 4'd6,  COND_VS = 4'd7,
    COND_VC = 4'd8,  COND_HI = 4'd9,  COND_LS = 4'd10, COND_GE = 4'd11,
    COND_LT = 4'd12, COND_GT = 4'd13, COND_LE = 4'd14, COND_NV = 4'd15
  } cond_e;

  typedef struct packed {
    logic [3:0]        optcode;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] result;
    logic [3:0]        flags;
    logic              set_flags;
    cond_e             cond;
  } wb_entry_t;

  // Condition-code test of a queued result against the committed NZVC flags.
  function automatic logic cond_pass(cond_e cond, logic [3:0] flags);
    logic n, z, v, c;
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    v = flags[FLAG_V];
    c = flags[FLAG_C];
    case (cond)
      COND_AL: cond_pass = 1'b1;
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c && !z;
      COND_LS: cond_pass = !c || z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z && (n == v);
      COND_LE: cond_pass = z || (n != v);
      COND_NV: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// ALU result handshake bundle: the ALU drives the master side, the writeback
// stage consumes on the slave side.
interface alu_writeback_if;
  import alu_writeback_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [3:0]          in_optcode;
  logic [ADDR_W-1:0]   in_rd;
  logic [DATA_W-1:0]   in_result;
  logic [3:0]          in_flags;
  logic                in_set_flags;
  logic [3:0]          in_cond;

  modport master (
    output in_valid, in_optcode, in_rd, in_result, in_flags, in_set_flags, in_cond,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_optcode, in_rd, in_result, in_flags, in_set_flags, in_cond,
    output in_ready
  );
endinterface

// File: rtl/alu_writeback_fifo.sv
// Synchronous result FIFO holding queued ALU results until they can commit.
module alu_writeback_fifo
  import alu_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t wr_data,
  input  logic      pop,
  output wb_entry_t rd_data,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  assign full    = (count_r == CNT_W'(DEPTH));
  assign empty   = (count_r == CNT_W'(0));
  assign push_s  = push && !full;
  assign pop_s   = pop && !empty;
  assign rd_data = mem_r[rd_ptr_r];

  // Storage array; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: queues ALU results, gates them on condition codes and
// commits to the register file / NZVC flags. Define ALU_WB_FWD_EN for read bypass.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NREGS = 16
) (
  input  logic              clk,
  input  logic              reset,
  alu_writeback_if.slave    bus,
  input  logic              ld_wr_en,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [3:0]        flags_n_z_v_c,
  output logic              commit_valid,
  output logic              commit_exec
);

  logic [DATA_W-1:0] regs_r [NREGS];
  logic [3:0]        flags_r;
  logic              commit_valid_r;
  logic              commit_exec_r;

  wb_entry_t         push_entry_s;
  wb_entry_t         head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic              pop_s;
  logic              exec_s;
  logic              flag_wr_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;

  assign bus.in_ready = !fifo_full_s && !reset;
  assign push_s       = bus.in_valid && bus.in_ready;

  assign push_entry_s = '{
    optcode:   bus.in_optcode,
    rd:        bus.in_rd,
    result:    bus.in_result,
    flags:     bus.in_flags,
    set_flags: bus.in_set_flags,
    cond:      cond_e'(bus.in_cond)
  };

  alu_writeback_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .wr_data (push_entry_s),
    .pop     (pop_s),
    .rd_data (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Commit decision and the single shared write port; loads take the port and stall the FIFO.
  always_comb begin
    pop_s     = !fifo_empty_s && !ld_wr_en && !reset;
    exec_s    = pop_s && cond_pass(head_s.cond, flags_r);
    flag_wr_s = exec_s && (head_s.set_flags || (head_s.optcode == OP_CMP));
    wr_en_s   = 1'b0;
    wr_addr_s = ld_rd;
    wr_data_s = ld_data;
    if (reset) begin
      wr_en_s = 1'b0;
    end else if (ld_wr_en) begin
      wr_en_s = 1'b1;
    end else if (exec_s && (head_s.optcode != OP_CMP)) begin
      wr_en_s   = 1'b1;
      wr_addr_s = head_s.rd;
      wr_data_s = head_s.result;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Register file; every entry is writable, including R0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      regs_r[wr_addr_s] <= wr_data_s;
    end else begin
      regs_r <= regs_r;
    end
  end

  // Status flags and the per-edge commit pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r        <= 4'b0000;
      commit_valid_r <= 1'b0;
      commit_exec_r  <= 1'b0;
    end else begin
      commit_valid_r <= pop_s;
      commit_exec_r  <= exec_s;
      if (flag_wr_s) begin
        flags_r <= head_s.flags;
      end
    end
  end

  assign flags_n_z_v_c = flags_r;
  assign commit_valid  = commit_valid_r;
  assign commit_exec   = commit_exec_r;

`ifdef ALU_WB_FWD_EN
  // Read ports show the value being written this edge when the address matches.
  always_comb begin
    rd_data_a = regs_r[rd_addr_a];
    rd_data_b = regs_r[rd_addr_b];
    if (wr_en_s && (wr_addr_s == rd_addr_a)) begin
      rd_data_a = wr_data_s;
    end else begin
      rd_data_a = regs_r[rd_addr_a];
    end
    if (wr_en_s && (wr_addr_s == rd_addr_b)) begin
      rd_data_b = wr_data_s;
    end else begin
      rd_data_b = regs_r[rd_addr_b];
    end
  end
`else
  assign rd_data_a = regs_r[rd_addr_a];
  assign rd_data_b = regs_r[rd_addr_b];
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios followed by random
// traffic, all checked against a queue/array reference model.
module tb_alu_writeback;

  logic        clk;
  logic        reset;
  logic        ld_wr_en;
  logic [3:0]  ld_rd;
  logic [31:0] ld_data;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [3:0]  flags_n_z_v_c;
  logic        commit_valid;
  logic        commit_exec;

  alu_writeback_if bus ();

  alu_writeback dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .ld_wr_en      (ld_wr_en),
    .ld_rd         (ld_rd),
    .ld_data       (ld_data),
    .rd_addr_a     (rd_addr_a),
    .rd_addr_b     (rd_addr_b),
    .rd_data_a     (rd_data_a),
    .rd_data_b     (rd_data_b),
    .flags_n_z_v_c (flags_n_z_v_c),
    .commit_valid  (commit_valid),
    .commit_exec   (commit_exec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [31:0] res;
    logic [3:0]  fl;
    logic        sf;
    logic [3:0]  cond;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mregs [16];
  logic [3:0]  mflags;
  logic        exp_cv;
  logic        exp_ce;
  int          errors = 0;
  int          checks = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
    bit n, z, v, cy;
    n = f[3]; z = f[2]; v = f[1]; cy = f[0];
    case (c)
      4'd0:  return 1'b1;
      4'd1:  return z;
      4'd2:  return !z;
      4'd3:  return cy;
      4'd4:  return !cy;
      4'd5:  return n;
      4'd6:  return !n;
      4'd7:  return v;
      4'd8:  return !v;
      4'd9:  return cy && !z;
      4'd10: return !cy || z;
      4'd11: return n == v;
      4'd12: return n != v;
      4'd13: return !z && (n == v);
      4'd14: return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  // Value a read port should show right now, given the write the next edge will perform.
  function automatic logic [31:0] model_read(logic [3:0] a);
`ifdef ALU_WB_FWD_EN
    if (!reset) begin
      if (ld_wr_en) begin
        if (ld_rd == a) return ld_data;
      end else if (mq.size() > 0) begin
        if (cond_ok(mq[0].cond, mflags) && mq[0].op != 4'd9 && mq[0].rd == a) return mq[0].res;
      end
    end
`endif
    return mregs[a];
  endfunction

  task automatic model_edge();
    bit   rdy;
    ent_t e;
    if (reset) begin
      mq.delete();
      for (int i = 0; i < 16; i++) mregs[i] = 32'd0;
      mflags = 4'd0;
      exp_cv = 1'b0;
      exp_ce = 1'b0;
    end else begin
      rdy    = mq.size() < 2;
      exp_cv = 1'b0;
      exp_ce = 1'b0;
      if (!ld_wr_en && mq.size() > 0) begin
        e = mq.pop_front();
        exp_cv = 1'b1;
        if (cond_ok(e.cond, mflags)) begin
          exp_ce = 1'b1;
          if (e.op != 4'd9) mregs[e.rd] = e.res;
          if (e.sf || e.op == 4'd9) mflags = e.fl;
        end
      end
      if (ld_wr_en) mregs[ld_rd] = ld_data;
      if (bus.in_valid && rdy) begin
        e.op = bus.in_optcode; e.rd = bus.in_rd; e.res = bus.in_result;
        e.fl = bus.in_flags; e.sf = bus.in_set_flags; e.cond = bus.in_cond;
        mq.push_back(e);
      end
    end
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic tick();
    #1;
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, (!reset && mq.size() < 2)});
    check("rd_data_a", rd_data_a, model_read(rd_addr_a));
    check("rd_data_b", rd_data_b, model_read(rd_addr_b));
    model_edge();
    @(posedge clk);
    #1;
    check("commit_valid", {31'd0, commit_valid}, {31'd0, exp_cv});
    check("commit_exec", {31'd0, commit_exec}, {31'd0, exp_ce});
    check("flags", {28'd0, flags_n_z_v_c}, {28'd0, mflags});
  endtask

  task automatic push(logic [3:0] op, logic [3:0] rd, logic [31:0] res,
                      logic [3:0] fl, logic sf, logic [3:0] cond);
    bus.in_valid = 1'b1; bus.in_optcode = op; bus.in_rd = rd; bus.in_result = res;
    bus.in_flags = fl; bus.in_set_flags = sf; bus.in_cond = cond;
  endtask

  task automatic peek(string tag, logic [3:0] a, logic [31:0] exp);
    rd_addr_a = a;
    #1;
    check(tag, rd_data_a, exp);
  endtask

  initial begin
    logic [31:0] r7;
    reset = 1'b1; ld_wr_en = 1'b0; ld_rd = 4'd0; ld_data = 32'd0;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    bus.in_valid = 1'b0; bus.in_optcode = 4'd0; bus.in_rd = 4'd0; bus.in_result = 32'd0;
    bus.in_flags = 4'd0; bus.in_set_flags = 1'b0; bus.in_cond = 4'd0;
    mflags = 4'd0; exp_cv = 1'b0; exp_ce = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = 32'd0;
    @(posedge clk); #1;
    tick();
    check("reset_ready", {31'd0, bus.in_ready}, 32'd0);
    reset = 1'b0;

    // ADD R3=6, AL, set flags 0000
    push(4'd0, 4'd3, 32'd6, 4'b0000, 1'b1, 4'd0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("add_exec", {31'd0, commit_exec}, 32'd1);
    peek("add_r3", 4'd3, 32'd6);

    // CMP sets Z, following EQ executes
    push(4'd9, 4'd5, 32'd0, 4'b0100, 1'b0, 4'd0);
    tick();
    push(4'd0, 4'd2, 32'd7, 4'b0000, 1'b0, 4'd1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("cmp_flags", {28'd0, flags_n_z_v_c}, 32'h4);
    peek("cmp_r5", 4'd5, 32'd0);
    peek("eq_r2", 4'd2, 32'd7);

    // Clear Z, then NE writes R1=9 and EQ is squashed
    push(4'd0, 4'd0, 32'd0, 4'b0000, 1'b1, 4'd0);
    tick();
    push(4'd0, 4'd1, 32'd9, 4'b0000, 1'b0, 4'd2);
    tick();
    push(4'd0, 4'd1, 32'd4, 4'b0000, 1'b0, 4'd1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("eq_squash_valid", {31'd0, commit_valid}, 32'd1);
    check("eq_squash_exec", {31'd0, commit_exec}, 32'd0);
    peek("ne_r1", 4'd1, 32'd9);

    // Loads hold the FIFO for three cycles while three results arrive
    ld_wr_en = 1'b1; ld_rd = 4'd8; ld_data = 32'h1111_0008;
    push(4'd0, 4'd10, 32'hA0, 4'd0, 1'b0, 4'd0);
    tick();
    ld_rd = 4'd9; ld_data = 32'h1111_0009;
    push(4'd0, 4'd11, 32'hB0, 4'd0, 1'b0, 4'd0);
    tick();
    ld_rd = 4'd6; ld_data = 32'h1111_0006;
    push(4'd0, 4'd12, 32'hC0, 4'd0, 1'b0, 4'd0);
    #1;
    check("full_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    ld_wr_en = 1'b0;
    tick();
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    peek("ld_r10", 4'd10, 32'hA0);
    peek("ld_r11", 4'd11, 32'hB0);
    peek("ld_r12", 4'd12, 32'hC0);
    peek("ld_r9", 4'd9, 32'h1111_0009);

    // Load R7 with read port A watching it
    ld_wr_en = 1'b1; ld_rd = 4'd7; ld_data = 32'hDEAD_BEEF;
    rd_addr_a = 4'd7;
    #1;
`ifdef ALU_WB_FWD_EN
    r7 = 32'hDEAD_BEEF;
`else
    r7 = 32'd0;
`endif
    check("fwd_r7", rd_data_a, r7);
    tick();
    ld_wr_en = 1'b0;
    peek("ld_r7", 4'd7, 32'hDEAD_BEEF);

    // Reset with two entries queued behind a load
    ld_wr_en = 1'b1; ld_rd = 4'd13; ld_data = 32'h5555_0013;
    push(4'd0, 4'd14, 32'hE0, 4'b1111, 1'b1, 4'd0);
    tick();
    push(4'd0, 4'd15, 32'hF0, 4'b1111, 1'b1, 4'd0);
    tick();
    bus.in_valid = 1'b0; ld_wr_en = 1'b0; reset = 1'b1;
    tick();
    check("rst_no_commit", {31'd0, commit_valid}, 32'd0);
    reset = 1'b0;
    tick();
    check("rst_no_commit2", {31'd0, commit_valid}, 32'd0);
    check("rst_flags", {28'd0, flags_n_z_v_c}, 32'd0);
    peek("rst_r13", 4'd13, 32'd0);
    peek("rst_r3", 4'd3, 32'd0);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      reset            = ($urandom_range(0, 99) == 0);
      ld_wr_en         = ($urandom_range(0, 4) == 0);
      ld_rd            = 4'($urandom_range(0, 15));
      ld_data          = $urandom;
      rd_addr_a        = 4'($urandom_range(0, 15));
      rd_addr_b        = 4'($urandom_range(0, 15));
      bus.in_valid     = ($urandom_range(0, 9) < 6);
      bus.in_optcode   = 4'($urandom_range(0, 9));
      bus.in_rd        = 4'($urandom_range(0, 15));
      bus.in_result    = $urandom;
      bus.in_flags     = 4'($urandom_range(0, 15));
      bus.in_set_flags = 1'($urandom_range(0, 1));
      bus.in_cond      = 4'($urandom_range(0, 15));
      tick();
    end

    // Drain and sweep every register through both ports
    reset = 1'b0; ld_wr_en = 1'b0; bus.in_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i);
      rd_addr_b = 4'(15 - i);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
